// File: rtl/atan2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : atan2_pkg                                              |
// | Description : Shared types for the Atan2 core request scheduler:     |
// |               default operand width, FSM state enum, in-flight tag.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package atan2_pkg;

    // Default signed width of x, y and theta
    localparam int c_data_w_default = 18;

    // Tag id is sized for the largest supported requester count (8)
    localparam int c_tag_id_w = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One slot of the tag pipe that shadows the core latency
    typedef struct packed {
        logic                  valid;
        logic [c_tag_id_w-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/atan2_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arbiter                                             |
// | Description : NUM_REQ-wide round-robin arbiter. Search starts one    |
// |               position after the last granted index; the pointer     |
// |               only moves when a grant is issued.                     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,        // asynchronous, active-low
    input  logic               en_i,         // grant allowed this cycle
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,      // one-hot, combinational on req_i
    output logic [PTR_W-1:0]   grant_idx_o
);

    logic [PTR_W-1:0] ptr_q;
    logic             w_found;
    int               w_cand;
    logic [PTR_W-1:0] w_cand_idx;

    // Circular search from ptr_q+1; first requesting index wins
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        w_found     = 1'b0;
        w_cand      = 0;
        w_cand_idx  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = int'(ptr_q) + off;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_idx = PTR_W'(w_cand);
            if (en_i && !w_found && req_i[w_cand_idx]) begin
                w_found             = 1'b1;
                grant_o[w_cand_idx] = 1'b1;
                grant_idx_o         = w_cand_idx;
            end
        end
    end

    // Pointer remembers the last granted index; reset makes index 0 first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= PTR_W'(NUM_REQ - 1);
        end else if (w_found) begin
            ptr_q <= grant_idx_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/atan2_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : atan2_scheduler                                        |
// | Description : Shares one fixed-latency Atan2 core between NUM_REQ    |
// |               requesters. Round-robin grant, registered core drive,  |
// |               tag pipe matching core latency, tagged result          |
// |               broadcast, flush/drain control.                        |
// | Option      : ATAN2_SCHEDULER_CHECK_EN enables the sticky            |
// |               core-valid vs tag-valid mismatch checker.              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module atan2_scheduler
    import atan2_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int CORE_LATENCY = 8,
    parameter  int DATA_W       = c_data_w_default,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,          // asynchronous, active-low
    input  logic                           clk_enable,
    output logic                           ce_out,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_y,          // two's complement per requester
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_x,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic signed [DATA_W-1:0]       core_y,
    output logic signed [DATA_W-1:0]       core_x,
    output logic                           core_valid_in,
    input  logic signed [DATA_W-1:0]       core_theta,
    input  logic                           core_valid_out,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic signed [DATA_W-1:0]       rsp_theta,
    input  logic                           flush,
    output logic                           flush_done,
    output logic                           err_mismatch
);

    state_t            state_q;
    logic              flush_done_q;

    logic              w_grant_en;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]   w_accept_idx;
    logic              w_accept;

    logic [DATA_W-1:0] core_x_q;
    logic [DATA_W-1:0] core_y_q;
    logic              core_valid_in_q;

    // tag_in_q sits in the same cycle as core_valid_in; pipe_q then
    // tracks the core's CORE_LATENCY stages so its last slot lines up
    // with core_valid_out.
    tag_t              tag_in_q;
    tag_t              pipe_q [CORE_LATENCY];
    tag_t              w_head;
    logic              w_pipe_busy;
    logic              w_rsp_fire;

    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [DATA_W-1:0] rsp_theta_q;

    // Grants stop in reset, in DRAIN, on stall and as soon as flush is seen
    assign w_grant_en = reset & clk_enable & ~flush & (state_q != ST_DRAIN);
    assign w_accept   = |w_grant;
    assign w_head     = pipe_q[CORE_LATENCY-1];

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_rr_arbiter (
        .clk         (clk),
        .reset       (reset),
        .en_i        (w_grant_en),
        .req_i       (req_valid),
        .grant_o     (w_grant),
        .grant_idx_o (w_accept_idx)
    );

    // Pipe is empty when no tag is anywhere between core input and output
    always_comb begin
        w_pipe_busy = tag_in_q.valid;
        for (int i = 0; i < CORE_LATENCY; i++) begin
            w_pipe_busy = w_pipe_busy | pipe_q[i].valid;
        end
    end

`ifdef ATAN2_SCHEDULER_CHECK_EN
    logic err_q;

    assign w_rsp_fire = w_head.valid & core_valid_out;

    // Sticky flag: core output valid must always agree with the tag head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (clk_enable && (core_valid_out != w_head.valid)) begin
            err_q <= 1'b1;
        end
    end

    assign err_mismatch = err_q;
`else
    assign w_rsp_fire   = w_head.valid;
    assign err_mismatch = 1'b0;
`endif

    // Upper id bits are unused for small NUM_REQ; core_valid_out is unused without the checker
    logic w_unused_sink;
    assign w_unused_sink = ^{w_head.id, core_valid_out};

    // Control FSM: IDLE/RUN grant, DRAIN waits for the tag pipe to empty
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            flush_done_q <= 1'b0;
        end else if (clk_enable) begin
            flush_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        state_q <= ST_DRAIN;
                    end else if (|req_valid) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_q <= ST_DRAIN;
                    end else if (!(|req_valid) && !w_pipe_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (!w_pipe_busy) begin
                        state_q      <= ST_IDLE;
                        flush_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Core drive, tag pipe and response register all freeze on stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_x_q        <= '0;
            core_y_q        <= '0;
            core_valid_in_q <= 1'b0;
            tag_in_q        <= '0;
            for (int i = 0; i < CORE_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_theta_q     <= '0;
        end else if (clk_enable) begin
            core_valid_in_q <= w_accept;
            if (w_accept) begin
                core_x_q <= req_x[w_accept_idx];
                core_y_q <= req_y[w_accept_idx];
            end
            tag_in_q.valid <= w_accept;
            tag_in_q.id    <= c_tag_id_w'(w_accept_idx);
            for (int i = CORE_LATENCY - 1; i > 0; i--) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            pipe_q[0]   <= tag_in_q;
            rsp_valid_q <= w_rsp_fire;
            if (w_rsp_fire) begin
                rsp_id_q    <= w_head.id[ID_W-1:0];
                rsp_theta_q <= core_theta;
            end
        end
    end

    assign ce_out        = clk_enable;
    assign req_ready     = w_grant;
    assign core_x        = core_x_q;
    assign core_y        = core_y_q;
    assign core_valid_in = core_valid_in_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_theta     = rsp_theta_q;
    assign flush_done    = flush_done_q;

endmodule
`default_nettype wire

// File: tb/tb_atan2_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_atan2_scheduler                                     |
// | Description : Self-checking bench for atan2_scheduler with a         |
// |               fixed-latency core model and a transaction-level       |
// |               reference (queue of accepted items with due times).    |
// |               Honours ATAN2_SCHEDULER_CHECK_EN for the drop test.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_atan2_scheduler;

    localparam int N = 4;
    localparam int L = 8;
    localparam int W = 18;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b1;
    logic               clk_enable;
    logic               ce_out;
    logic [N-1:0]       req_valid;
    logic [N-1:0][W-1:0] req_y;
    logic [N-1:0][W-1:0] req_x;
    logic [N-1:0]       req_ready;
    logic [W-1:0]       core_y, core_x, core_theta;
    logic               core_valid_in, core_valid_out;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [W-1:0]       rsp_theta;
    logic               flush, flush_done, err_mismatch;

    always #5 clk = ~clk;

    atan2_scheduler #(
        .NUM_REQ        (N),
        .CORE_LATENCY   (L),
        .DATA_W         (W)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .clk_enable     (clk_enable),
        .ce_out         (ce_out),
        .req_valid      (req_valid),
        .req_y          (req_y),
        .req_x          (req_x),
        .req_ready      (req_ready),
        .core_y         (core_y),
        .core_x         (core_x),
        .core_valid_in  (core_valid_in),
        .core_theta     (core_theta),
        .core_valid_out (core_valid_out),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_theta      (rsp_theta),
        .flush          (flush),
        .flush_done     (flush_done),
        .err_mismatch   (err_mismatch)
    );

    // Arbitrary but input-dependent "angle" so ids and data can be told apart
    function automatic logic [W-1:0] theta_fn(input logic [W-1:0] x, input logic [W-1:0] y);
        return (x * 18'd3) ^ (y + 18'd7);
    endfunction

    // ---------------- core model: L-stage pipe, stalls with clk_enable ----
    logic         cm_v  [L];
    logic [W-1:0] cm_th [L];
    int           cm_acc;
    int           drop_target = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin
                cm_v[i]  <= 1'b0;
                cm_th[i] <= '0;
            end
            cm_acc <= 0;
        end else if (clk_enable) begin
            for (int i = L - 1; i > 0; i--) begin
                cm_v[i]  <= cm_v[i-1];
                cm_th[i] <= cm_th[i-1];
            end
            cm_v[0]  <= core_valid_in && (cm_acc != drop_target);
            cm_th[0] <= theta_fn(core_x, core_y);
            if (core_valid_in) cm_acc <= cm_acc + 1;
        end
    end

    assign core_valid_out = cm_v[L-1];
    assign core_theta     = cm_th[L-1];

    // ---------------- reference model -----------------------------------
    typedef struct {
        int           id;
        logic [W-1:0] th;
        int           due;
        bit           drop;
    } item_t;

    item_t        q[$];
    int           last_g;
    int           en_edges;
    int           n_acc;
    bit           draining;
    logic         exp_rv, exp_cvi, exp_fd, exp_err;
    logic [1:0]   exp_id;
    logic [W-1:0] exp_th, exp_cx, exp_cy;

    int           n_total = 0;
    int           n_bad   = 0;
    logic [N-1:0] last_ready;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_g   = N - 1;
        en_edges = 0;
        n_acc    = 0;
        draining = 1'b0;
        exp_rv = 0; exp_cvi = 0; exp_fd = 0; exp_err = 0;
        exp_id = '0; exp_th = '0; exp_cx = '0; exp_cy = '0;
    endtask

    // Next requester after the last granted one, if granting is allowed
    function automatic int model_grant();
        if (!(rst_n && clk_enable && !flush && !draining)) return -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last_g + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input int mg);
        bit    empty;
        item_t it;
        if (!rst_n || !clk_enable) return;
        en_edges++;
        empty  = (q.size() == 0);
        exp_fd = 1'b0;
        if (q.size() > 0 && q[0].due == en_edges) begin
            if (q[0].drop) begin
                exp_rv  = 1'b0;
                exp_err = 1'b1;
            end else begin
                exp_rv = 1'b1;
                exp_id = 2'(q[0].id);
                exp_th = q[0].th;
            end
            void'(q.pop_front());
        end else begin
            exp_rv = 1'b0;
        end
        if (!draining && flush) begin
            draining = 1'b1;
        end else if (draining && empty) begin
            draining = 1'b0;
            exp_fd   = 1'b1;
        end
        if (mg >= 0) begin
            it.id   = mg;
            it.th   = theta_fn(req_x[mg], req_y[mg]);
            it.due  = en_edges + L + 1;
            it.drop = (n_acc == drop_target);
            q.push_back(it);
            n_acc++;
            last_g  = mg;
            exp_cvi = 1'b1;
            exp_cx  = req_x[mg];
            exp_cy  = req_y[mg];
        end else begin
            exp_cvi = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check_val("core_valid_in", core_valid_in, exp_cvi);
        check_val("core_x", core_x, exp_cx);
        check_val("core_y", core_y, exp_cy);
        check_val("rsp_valid", rsp_valid, exp_rv);
        check_val("rsp_id", rsp_id, exp_id);
        check_val("rsp_theta", rsp_theta, exp_th);
        check_val("flush_done", flush_done, exp_fd);
        check_val("err_mismatch", err_mismatch, exp_err);
    endtask

    // One clock: inputs were set at the preceding negedge
    task automatic cycle();
        int mg;
        #1;
        mg = model_grant();
        last_ready = req_ready;
        check_val("req_ready", req_ready, (mg >= 0) ? (32'd1 << mg) : 32'd0);
        check_val("ce_out", ce_out, clk_enable);
        @(posedge clk);
        model_edge(mg);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int k, cnt, pulses, grants;
        bit seen;
        int fl_cnt;

        clk_enable = 1'b1;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        flush      = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_outputs();
        #1;
        check_val("reset_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 2, 10-cycle response latency
        req_valid = 4'b0100;
        req_x[2]  = 18'd100;
        req_y[2]  = 18'd100;
        cycle();
        check_val("single_grant", last_ready, 4'b0100);
        req_valid = '0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            cycle();
            k++;
            if (rsp_valid) seen = 1'b1;
        end
        check_val("single_latency", k, 9);
        check_val("single_id", rsp_id, 2);
        idle(3);

        // All four requesters continuously valid: 0,1,2,3,0,1,2,3
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_x[i] = 18'(1000 + i);
            req_y[i] = 18'(2000 + 7 * i);
        end
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            cycle();
            check_val("rr_seq", last_ready, 32'd1 << (c % 4));
        end
        req_valid = '0;
        cnt = 0;
        for (int c = 0; c < 14; c++) begin
            cycle();
            if (rsp_valid) begin
                check_val("rr_rsp_order", rsp_id, cnt % 4);
                cnt++;
            end
        end
        check_val("rr_rsp_count", cnt, 8);

        // Stream on 1 and 3, flush from cycle 5 until drained
        do_reset();
        req_valid = 4'b1010;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (rsp_valid) cnt++;
        end
        flush  = 1'b1;
        grants = 0;
        pulses = 0;
        k      = 0;
        seen   = 1'b0;
        while (!seen && k < 40) begin
            cycle();
            k++;
            if (last_ready != 0) grants++;
            if (rsp_valid) cnt++;
            if (flush_done) begin
                seen = 1'b1;
                pulses++;
            end
        end
        check_val("flush_done_seen", seen, 1);
        check_val("flush_no_grant", grants, 0);
        check_val("flush_rsp_count", cnt, 5);
        flush     = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (flush_done) pulses++;
        end
        check_val("flush_pulses", pulses, 1);

        // Three-cycle stall in the middle of a stream
        req_valid = 4'b0011;
        for (int c = 0; c < 4; c++) cycle();
        clk_enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check_val("stall_no_grant", last_ready, 0);
        end
        clk_enable = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        idle(14);

        // Reset with four items in flight
        req_valid = 4'hF;
        for (int c = 0; c < 4; c++) cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("rst_ready", req_ready, 0);
        check_outputs();
        @(negedge clk);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        cnt = 0;
        for (int c = 0; c < L + 6; c++) begin
            cycle();
            if (rsp_valid) cnt++;
        end
        check_val("rst_no_rsp", cnt, 0);

`ifdef ATAN2_SCHEDULER_CHECK_EN
        // Core drops the second result: sticky mismatch until reset
        do_reset();
        drop_target = 1;
        req_valid = 4'b0111;
        for (int c = 0; c < 3; c++) cycle();
        idle(L + 8);
        check_val("err_sticky", err_mismatch, 1);
        do_reset();
        drop_target = -1;
        cycle();
        check_val("err_cleared", err_mismatch, 0);
`endif

        // Randomized traffic with random stalls and flushes
        do_reset();
        fl_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_x[i] = W'($urandom);
                req_y[i] = W'($urandom);
            end
            clk_enable = ($urandom_range(0, 9) != 0);
            if (fl_cnt > 0) fl_cnt--;
            else if ($urandom_range(0, 59) == 0) fl_cnt = $urandom_range(1, 15);
            flush = (fl_cnt > 0);
            cycle();
        end
        clk_enable = 1'b1;
        flush      = 1'b0;
        idle(L + 6);
        check_val("final_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
